// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, the FSM state type
// and helpers that decode access size and legality.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } lsu_state_e;

    // Byte lanes touched by an access of the given size, before lane shifting.
    function automatic logic [3:0] size_mask(input logic [2:0] f3);
        logic [3:0] m;
        case (f3)
            F3_B, F3_BU: m = 4'b0001;
            F3_H, F3_HU: m = 4'b0011;
            F3_W:        m = 4'b1111;
            default:     m = 4'b0000;
        endcase
        return m;
    endfunction

    // Unsigned variants only make sense for loads.
    function automatic logic f3_legal(input logic [2:0] f3, input logic we);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte-mask and store-data shifting across a two-word window,
// and extraction plus sign/zero extension of load data from that window.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [63:0] i_rdata64,
    output logic [7:0]  o_mask8,
    output logic [63:0] o_data64,
    output logic [31:0] o_load_data
);

    logic [4:0]  w_shift;
    logic [31:0] w_raw;

    assign w_shift  = {i_off, 3'b000};
    assign o_mask8  = {4'b0000, size_mask(i_funct3)} << i_off;
    assign o_data64 = {32'h0000_0000, i_wdata} << w_shift;
    assign w_raw    = i_rdata64[w_shift +: 32];

    always_comb begin
        o_load_data = '0;
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_raw[7]}}, w_raw[7:0]};
            F3_BU:   o_load_data = {24'h00_0000, w_raw[7:0]};
            F3_H:    o_load_data = {{16{w_raw[15]}}, w_raw[15:0]};
            F3_HU:   o_load_data = {16'h0000, w_raw[15:0]};
            F3_W:    o_load_data = w_raw;
            default: o_load_data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and data memory. Define LSU_MISALIGN_SPLIT_EN to split
// misaligned accesses over two cycles; otherwise misaligned accesses are flagged on misalign_o.
//   state     | meaning
//   ST_IDLE   | decode new request; aligned access completes, split access issues low word
//   ST_SECOND | issue high word of a split access and merge it with the captured low word
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    input  logic              req_we_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       load_data_o,
    output logic              stall_o,
    output logic              misalign_o,
    output logic [ADDR_W-1:0] mem_a_o,
    output logic [31:0]       mem_wd_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_wmask_o,
    input  logic [31:0]       mem_rd_i
);

    lsu_state_e        r_state;
    lsu_state_e        w_state_nxt;
    logic [31:0]       r_lo_q;
    logic              w_capture;
    logic              w_access;
    logic              w_cross;
    logic [7:0]        w_mask8;
    logic [63:0]       w_data64;
    logic [63:0]       w_rdata64;
    logic [31:0]       w_align_load;
    logic [ADDR_W-1:0] w_base_a;

    assign w_access  = req_valid_i & f3_legal(funct3_i, req_we_i);
    assign w_cross   = |w_mask8[7:4];
    assign w_base_a  = {addr_i[ADDR_W-1:2], 2'b00};
    assign w_rdata64 = (r_state == ST_SECOND) ? {mem_rd_i, r_lo_q} : {32'h0000_0000, mem_rd_i};

    lsu_align u_align (
        .i_funct3    (funct3_i),
        .i_off       (addr_i[1:0]),
        .i_wdata     (wdata_i),
        .i_rdata64   (w_rdata64),
        .o_mask8     (w_mask8),
        .o_data64    (w_data64),
        .o_load_data (w_align_load)
    );

    always_comb begin
        w_state_nxt = ST_IDLE;
        w_capture   = 1'b0;
        stall_o     = 1'b0;
        misalign_o  = 1'b0;
        mem_a_o     = w_base_a;
        mem_wd_o    = w_data64[31:0];
        mem_wmask_o = 4'b0000;
        mem_we_o    = 1'b0;
        load_data_o = '0;
        if (r_state == ST_SECOND) begin
            // A dropped request aborts here; the low half is already committed.
            if (w_access) begin
                mem_a_o     = w_base_a + ADDR_W'(4);
                mem_wd_o    = w_data64[63:32];
                mem_wmask_o = w_mask8[7:4];
                mem_we_o    = req_we_i;
                load_data_o = req_we_i ? 32'h0000_0000 : w_align_load;
            end
        end else if (w_access) begin
            if (!w_cross) begin
                mem_wmask_o = w_mask8[3:0];
                mem_we_o    = req_we_i;
                load_data_o = req_we_i ? 32'h0000_0000 : w_align_load;
            end else begin
`ifdef LSU_MISALIGN_SPLIT_EN
                mem_wmask_o = w_mask8[3:0];
                mem_we_o    = req_we_i;
                stall_o     = 1'b1;
                w_capture   = 1'b1;
                w_state_nxt = ST_SECOND;
`else
                misalign_o  = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_lo_q  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_lo_q <= mem_rd_i;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small byte-masked memory model.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] load_data;
    logic        stall;
    logic        misalign;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:63];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_we_i    (req_we),
        .funct3_i    (funct3),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .load_data_o (load_data),
        .stall_o     (stall),
        .misalign_o  (misalign),
        .mem_a_o     (mem_a),
        .mem_wd_o    (mem_wd),
        .mem_we_o    (mem_we),
        .mem_wmask_o (mem_wmask),
        .mem_rd_i    (mem_rd)
    );

    assign mem_rd = mem[mem_a[7:2]];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        forever begin
            @(posedge clk);
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wmask[b]) mem[mem_a[7:2]][8*b +: 8] <= mem_wd[8*b +: 8];
                end
            end
        end
    end

    typedef struct {
        logic        valid;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_we;
        logic        exp_mis;
        logic        chk_mem;
        logic [31:0] exp_a;
        logic [3:0]  exp_mask;
        logic [31:0] exp_wd;
        logic        chk_load;
        logic [31:0] exp_load;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic valid, logic we, logic [2:0] f3, logic [31:0] a,
                                logic [31:0] d, logic exp_we, logic exp_mis, logic chk_mem,
                                logic [31:0] exp_a, logic [3:0] exp_mask, logic [31:0] exp_wd,
                                logic chk_load, logic [31:0] exp_load);
        vec_t v;
        v.valid = valid; v.we = we; v.f3 = f3; v.addr = a; v.wdata = d;
        v.exp_we = exp_we; v.exp_mis = exp_mis; v.chk_mem = chk_mem;
        v.exp_a = exp_a; v.exp_mask = exp_mask; v.exp_wd = exp_wd;
        v.chk_load = chk_load; v.exp_load = exp_load;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        req_valid = v; req_we = we; funct3 = f3; addr = a; wdata = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // valid we f3 addr wdata | we mis chk_mem a mask wd | chk_load load
        vecs.push_back(mk(1, 1, F3_W,  32'h10, 32'hDEADBEEF, 1, 0, 1, 32'h10, 4'b1111, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(1, 1, F3_B,  32'h13, 32'h000000AB, 1, 0, 1, 32'h10, 4'b1000, 32'hAB000000, 0, 0));
        vecs.push_back(mk(1, 0, F3_B,  32'h13, 32'h0,        0, 0, 1, 32'h10, 4'b0000, 32'h0, 1, 32'hFFFFFFAB));
        vecs.push_back(mk(1, 0, F3_BU, 32'h13, 32'h0,        0, 0, 1, 32'h10, 4'b0000, 32'h0, 1, 32'h000000AB));
        vecs.push_back(mk(1, 0, F3_W,  32'h10, 32'h0,        0, 0, 1, 32'h10, 4'b0000, 32'h0, 1, 32'hABADBEEF));
        vecs.push_back(mk(1, 0, F3_H,  32'h12, 32'h0,        0, 0, 1, 32'h10, 4'b0000, 32'h0, 1, 32'hFFFFABAD));
        vecs.push_back(mk(1, 0, F3_HU, 32'h12, 32'h0,        0, 0, 1, 32'h10, 4'b0000, 32'h0, 1, 32'h0000ABAD));
        vecs.push_back(mk(1, 0, F3_H,  32'h10, 32'h0,        0, 0, 1, 32'h10, 4'b0000, 32'h0, 1, 32'hFFFFBEEF));
        vecs.push_back(mk(1, 1, F3_H,  32'h16, 32'h00007F01, 1, 0, 1, 32'h14, 4'b1100, 32'h7F010000, 0, 0));
        vecs.push_back(mk(1, 0, F3_H,  32'h16, 32'h0,        0, 0, 1, 32'h14, 4'b0000, 32'h0, 1, 32'h00007F01));
        vecs.push_back(mk(1, 0, F3_B,  32'h17, 32'h0,        0, 0, 1, 32'h14, 4'b0000, 32'h0, 1, 32'h0000007F));
        vecs.push_back(mk(1, 0, F3_B,  32'h16, 32'h0,        0, 0, 1, 32'h14, 4'b0000, 32'h0, 1, 32'h00000001));
        vecs.push_back(mk(1, 1, F3_B,  32'h11, 32'h12345680, 1, 0, 1, 32'h10, 4'b0010, 32'h34568000, 0, 0));
        vecs.push_back(mk(1, 0, F3_B,  32'h11, 32'h0,        0, 0, 1, 32'h10, 4'b0000, 32'h0, 1, 32'hFFFFFF80));
        vecs.push_back(mk(1, 0, F3_BU, 32'h11, 32'h0,        0, 0, 1, 32'h10, 4'b0000, 32'h0, 1, 32'h00000080));
        vecs.push_back(mk(1, 0, 3'b011, 32'h10, 32'h0,       0, 0, 0, 32'h0, 4'b0000, 32'h0, 1, 32'h0));
        vecs.push_back(mk(1, 0, 3'b111, 32'h10, 32'h0,       0, 0, 0, 32'h0, 4'b0000, 32'h0, 1, 32'h0));
        vecs.push_back(mk(1, 1, 3'b110, 32'h10, 32'hFFFFFFFF, 0, 0, 0, 32'h0, 4'b0000, 32'h0, 0, 0));
        vecs.push_back(mk(1, 1, F3_BU, 32'h10, 32'hFFFFFFFF, 0, 0, 0, 32'h0, 4'b0000, 32'h0, 0, 0));
        vecs.push_back(mk(1, 1, F3_HU, 32'h13, 32'hFFFFFFFF, 0, 0, 0, 32'h0, 4'b0000, 32'h0, 0, 0));
        vecs.push_back(mk(0, 1, F3_W,  32'h10, 32'hFFFFFFFF, 0, 0, 0, 32'h0, 4'b0000, 32'h0, 0, 0));
        vecs.push_back(mk(1, 0, F3_W,  32'h10, 32'h0,        0, 0, 1, 32'h10, 4'b0000, 32'h0, 1, 32'hABAD80EF));
`ifndef LSU_MISALIGN_SPLIT_EN
        vecs.push_back(mk(1, 1, F3_W,  32'h22, 32'h11223344, 0, 1, 0, 32'h0, 4'b0000, 32'h0, 0, 0));
        vecs.push_back(mk(1, 0, F3_W,  32'h21, 32'h0,        0, 1, 0, 32'h0, 4'b0000, 32'h0, 1, 32'h0));
        vecs.push_back(mk(1, 0, F3_H,  32'h13, 32'h0,        0, 1, 0, 32'h0, 4'b0000, 32'h0, 1, 32'h0));
        vecs.push_back(mk(1, 0, F3_W,  32'h20, 32'h0,        0, 0, 1, 32'h20, 4'b0000, 32'h0, 1, 32'h0));
        vecs.push_back(mk(1, 0, F3_W,  32'h24, 32'h0,        0, 0, 1, 32'h24, 4'b0000, 32'h0, 1, 32'h0));
        vecs.push_back(mk(1, 1, F3_H,  32'h1E, 32'h0000BEAD, 1, 0, 1, 32'h1C, 4'b1100, 32'hBEAD0000, 0, 0));
        vecs.push_back(mk(1, 0, F3_HU, 32'h1E, 32'h0,        0, 0, 1, 32'h1C, 4'b0000, 32'h0, 1, 32'h0000BEAD));
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_misalign", 32'(misalign), 32'd0);
        chk("reset_we", 32'(mem_we), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].valid, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'd0);
            chk($sformatf("v%0d_misalign", i), 32'(misalign), 32'(vecs[i].exp_mis));
            chk($sformatf("v%0d_we", i), 32'(mem_we), 32'(vecs[i].exp_we));
            if (vecs[i].chk_mem) begin
                chk($sformatf("v%0d_addr", i), mem_a, vecs[i].exp_a);
                if (vecs[i].exp_we) begin
                    chk($sformatf("v%0d_mask", i), 32'(mem_wmask), 32'(vecs[i].exp_mask));
                    chk($sformatf("v%0d_wd", i), mem_wd, vecs[i].exp_wd);
                end
            end
            if (vecs[i].chk_load) chk($sformatf("v%0d_load", i), load_data, vecs[i].exp_load);
        end

`ifdef LSU_MISALIGN_SPLIT_EN
        drive(1, 1, F3_W, 32'h22, 32'h11223344);
        @(negedge clk);
        chk("sw_split0_stall", 32'(stall), 32'd1);
        chk("sw_split0_addr", mem_a, 32'h20);
        chk("sw_split0_mask", 32'(mem_wmask), 32'hC);
        chk("sw_split0_wd", mem_wd, 32'h33440000);
        chk("sw_split0_we", 32'(mem_we), 32'd1);
        chk("sw_split0_misalign", 32'(misalign), 32'd0);
        next_cycle();
        chk("sw_split1_stall", 32'(stall), 32'd0);
        chk("sw_split1_addr", mem_a, 32'h24);
        chk("sw_split1_mask", 32'(mem_wmask), 32'h3);
        chk("sw_split1_wd", mem_wd, 32'h00001122);
        chk("sw_split1_we", 32'(mem_we), 32'd1);

        drive(1, 0, F3_W, 32'h22, 32'h0);
        @(negedge clk);
        chk("lw_split0_stall", 32'(stall), 32'd1);
        chk("lw_split0_we", 32'(mem_we), 32'd0);
        next_cycle();
        chk("lw_split1_stall", 32'(stall), 32'd0);
        chk("lw_split1_load", load_data, 32'h11223344);

        drive(1, 1, F3_B, 32'h27, 32'h00000080);
        @(negedge clk);
        chk("sb27_mask", 32'(mem_wmask), 32'h8);
        drive(1, 1, F3_B, 32'h28, 32'h0000007F);
        @(negedge clk);
        chk("sb28_mask", 32'(mem_wmask), 32'h1);
        drive(1, 0, F3_H, 32'h27, 32'h0);
        @(negedge clk);
        chk("lh_split0_stall", 32'(stall), 32'd1);
        next_cycle();
        chk("lh_split1_stall", 32'(stall), 32'd0);
        chk("lh_split1_load", load_data, 32'h00007F80);

        drive(1, 1, F3_W, 32'h22, 32'h55667788);
        @(negedge clk);
        chk("rst_split0_stall", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_split_stall", 32'(stall), 32'd0);
        chk("rst_split_we", 32'(mem_we), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1, 0, F3_W, 32'h24, 32'h0);
        @(negedge clk);
        chk("rst_after_stall", 32'(stall), 32'd0);
        chk("rst_mem24", load_data, 32'h80001122);
        drive(1, 0, F3_W, 32'h20, 32'h0);
        @(negedge clk);
        chk("rst_mem20", load_data, 32'h77880000);

        drive(1, 0, F3_W, 32'h22, 32'h0);
        @(negedge clk);
        chk("abort0_stall", 32'(stall), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("abort1_stall", 32'(stall), 32'd0);
        chk("abort1_we", 32'(mem_we), 32'd0);
        drive(1, 0, F3_W, 32'h10, 32'h0);
        @(negedge clk);
        chk("abort_next_stall", 32'(stall), 32'd0);
        chk("abort_next_load", load_data, 32'hABAD80EF);
`endif

        drive(0, 0, F3_B, 32'h0, 32'h0);
        @(negedge clk);
        chk("idle_we", 32'(mem_we), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
